// File: rtl/load_pkg.sv
// Shared types and constants for the load writeback aligner.
package load_pkg;

    localparam int XLEN   = 32;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4,
        LD_W    = 3'd5
    } load_type_e;

    // Priority lw > lh > lhu > lb > lbu; lower-priority selects are ignored.
    function automatic load_type_e encode_load(input logic i_lb, input logic i_lbu,
                                               input logic i_lh, input logic i_lhu,
                                               input logic i_lw);
        load_type_e v_type;
        v_type = LD_NONE;
        if (i_lw)       v_type = LD_W;
        else if (i_lh)  v_type = LD_H;
        else if (i_lhu) v_type = LD_HU;
        else if (i_lb)  v_type = LD_B;
        else if (i_lbu) v_type = LD_BU;
        return v_type;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of a little-endian memory word.
module load_extend
    import load_pkg::*;
(
    input  load_type_e        load_type,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   raw_data,
    output logic [XLEN-1:0]   ext_data
);

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;

    // Pick the byte lane and halfword lane addressed by the low address bits.
    always_comb begin
        w_byte = raw_data[7:0];
        case (addr_lo)
            2'd0: w_byte = raw_data[7:0];
            2'd1: w_byte = raw_data[15:8];
            2'd2: w_byte = raw_data[23:16];
            2'd3: w_byte = raw_data[31:24];
            default: w_byte = raw_data[7:0];
        endcase
        w_half = addr_lo[1] ? raw_data[31:16] : raw_data[15:0];
    end

    // Extend the selected lane to the full register width; no load gives 0.
    always_comb begin
        ext_data = '0;
        case (load_type)
            LD_B:    ext_data = {{(XLEN-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
            LD_BU:   ext_data = {{(XLEN-BYTE_W){1'b0}}, w_byte};
            LD_H:    ext_data = {{(XLEN-HALF_W){w_half[HALF_W-1]}}, w_half};
            LD_HU:   ext_data = {{(XLEN-HALF_W){1'b0}}, w_half};
            LD_W:    ext_data = raw_data;
            default: ext_data = '0;
        endcase
    end

endmodule

// File: rtl/load_decoder_unit.sv
// Load writeback aligner: one-hot load selects -> lane-selected, extended, registered result.
// Optional macro LOAD_MISALIGN_CHECK_EN adds a registered misalignment flag for
// halfword loads at odd addresses and word loads at non-word-aligned addresses;
// without it the flag is constant 0.
module load_decoder_unit
    import load_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   raw_data,
    input  logic              lb,
    input  logic              lbu,
    input  logic              lh,
    input  logic              lhu,
    input  logic              lw,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_valid,
    output logic              misaligned
);

    load_type_e        w_load_type;
    logic [XLEN-1:0]   w_ext_data;
    logic              w_any_load;
    logic              w_unused_addr;

    logic [XLEN-1:0]   r_wb_data;
    logic              r_wb_valid;

    // Upper address bits only locate the word; they never reach the result.
    assign w_unused_addr = &{1'b0, addr[XLEN-1:2]};

    // Resolve simultaneous selects into a single load type.
    always_comb begin
        w_load_type = encode_load(lb, lbu, lh, lhu, lw);
        w_any_load  = (w_load_type != LD_NONE);
    end

    load_extend u_load_extend (
        .load_type (w_load_type),
        .addr_lo   (addr[1:0]),
        .raw_data  (raw_data),
        .ext_data  (w_ext_data)
    );

    // Result register: loads 0 when no select is active rather than holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_data  <= '0;
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_data  <= w_ext_data;
            r_wb_valid <= w_any_load;
        end
    end

    assign wb_data  = r_wb_data;
    assign wb_valid = r_wb_valid;

`ifdef LOAD_MISALIGN_CHECK_EN
    logic w_misaligned;
    logic r_misaligned;

    // Flag is diagnostic only; the data path still returns the lane-selected value.
    always_comb begin
        w_misaligned = 1'b0;
        case (w_load_type)
            LD_H, LD_HU: w_misaligned = addr[0];
            LD_W:        w_misaligned = (addr[1:0] != 2'b00);
            default:     w_misaligned = 1'b0;
        endcase
    end

    // Flag shares the result latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_misaligned <= 1'b0;
        else        r_misaligned <= w_misaligned;
    end

    assign misaligned = r_misaligned;
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_decoder_unit.sv
// Directed self-checking bench for load_decoder_unit.
module tb_load_decoder_unit;

`ifdef LOAD_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] raw_data;
    logic        lb, lbu, lh, lhu, lw;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic        misaligned;

    int n_checks;
    int n_fail;

    load_decoder_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .raw_data   (raw_data),
        .lb         (lb),
        .lbu        (lbu),
        .lh         (lh),
        .lhu        (lhu),
        .lw         (lw),
        .wb_data    (wb_data),
        .wb_valid   (wb_valid),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // sel = {lw, lh, lhu, lb, lbu}
    task automatic do_load(input string tag, input logic [4:0] sel, input logic [31:0] a,
                           input logic [31:0] raw, input logic [31:0] exp_data,
                           input logic exp_valid, input logic exp_mis);
        @(negedge clk);
        {lw, lh, lhu, lb, lbu} = sel;
        addr     = a;
        raw_data = raw;
        @(posedge clk);
        #1;
        check({tag, ".data"},  wb_data,           exp_data);
        check({tag, ".valid"}, {31'b0, wb_valid}, {31'b0, exp_valid});
        check({tag, ".mis"},   {31'b0, misaligned}, {31'b0, exp_mis & MIS_EN});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        addr     = 32'h0;
        raw_data = 32'h0;
        {lw, lh, lhu, lb, lbu} = 5'b0;

        #12;
        check("rst.data",  wb_data,             32'h0);
        check("rst.valid", {31'b0, wb_valid},   32'h0);
        check("rst.mis",   {31'b0, misaligned}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_load("lb_a0",  5'b00010, 32'h0, 32'h80008080, 32'hFFFFFF80, 1'b1, 1'b0);
        do_load("lbu_a0", 5'b00001, 32'h0, 32'h80008080, 32'h00000080, 1'b1, 1'b0);
        do_load("lh_a0",  5'b01000, 32'h0, 32'h80008080, 32'hFFFF8080, 1'b1, 1'b0);
        do_load("lhu_a0", 5'b00100, 32'h0, 32'h80008080, 32'h00008080, 1'b1, 1'b0);
        do_load("lw_a0",  5'b10000, 32'h0, 32'h80008080, 32'h80008080, 1'b1, 1'b0);
        do_load("lb_a2",  5'b00010, 32'h2, 32'h80008080, 32'h00000000, 1'b1, 1'b0);
        do_load("lh_a2",  5'b01000, 32'h2, 32'h80008080, 32'hFFFF8000, 1'b1, 1'b0);
        do_load("lhu_a2", 5'b00100, 32'h2, 32'h80008080, 32'h00008000, 1'b1, 1'b0);
        do_load("lb_a3",  5'b00010, 32'h3, 32'h7F3C8001, 32'h0000007F, 1'b1, 1'b0);
        do_load("lbu_a1", 5'b00001, 32'h1, 32'h7F3C8001, 32'h00000080, 1'b1, 1'b0);
        do_load("lw_lb",  5'b10010, 32'h0, 32'h12345678, 32'h12345678, 1'b1, 1'b0);
        do_load("none",   5'b00000, 32'h0, 32'h12345678, 32'h00000000, 1'b0, 1'b0);
        do_load("hi_lbu", 5'b00001, 32'hFFFFFFF1, 32'h7F3C8001, 32'h00000080, 1'b1, 1'b0);
        do_load("hi_lhu", 5'b00100, 32'hABCD0003, 32'h7F3C8001, 32'h00007F3C, 1'b1, 1'b1);
        do_load("lh_lhu", 5'b01100, 32'h0, 32'h7F3C8001, 32'hFFFF8001, 1'b1, 1'b0);
        do_load("lhu_lb", 5'b00110, 32'h2, 32'h80008080, 32'h00008000, 1'b1, 1'b0);
        do_load("lb_lbu", 5'b00011, 32'h0, 32'h80008080, 32'hFFFFFF80, 1'b1, 1'b0);
        do_load("lw_a1",  5'b10000, 32'h1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b1);
        do_load("lh_a1",  5'b01000, 32'h1, 32'h80008080, 32'hFFFF8080, 1'b1, 1'b1);
        do_load("lw_a2",  5'b10000, 32'h2, 32'h80008080, 32'h80008080, 1'b1, 1'b1);
        do_load("lb_a3m", 5'b00010, 32'h3, 32'h80008080, 32'hFFFFFF80, 1'b1, 1'b0);

        // Leave a nonzero, valid (and possibly flagged) result, then reset between edges.
        do_load("pre_rst", 5'b10000, 32'h2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.data",  wb_data,             32'h0);
        check("arst.valid", {31'b0, wb_valid},   32'h0);
        check("arst.mis",   {31'b0, misaligned}, 32'h0);
        @(posedge clk);
        #1;
        check("arst_hold.data",  wb_data,           32'h0);
        check("arst_hold.valid", {31'b0, wb_valid}, 32'h0);
        @(negedge clk);
        {lw, lh, lhu, lb, lbu} = 5'b0;
        rst_n = 1'b1;

        do_load("post_rst", 5'b00010, 32'h1, 32'h0000FF00, 32'hFFFFFFFF, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
